// File: rtl/mux_l1.sv
// Four-lane to two-lane layer-1 transmit serialiser: words 0/1 go out on lane 00,
// words 2/3 on lane 11, one 4-word group every two clk_2f cycles.
module mux_l1 (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  input  logic [7:0] data_2,
  input  logic [7:0] data_3,
  input  logic       valid_0,
  input  logic       valid_1,
  input  logic       valid_2,
  input  logic       valid_3,
  output logic [7:0] data_00,
  output logic [7:0] data_11,
  output logic       valid_00,
  output logic       valid_11,
  output logic       slot_b,
  output logic [7:0] group_cnt
);

  localparam int DATA_W = 8;

  logic              phase;
  logic [DATA_W-1:0] h_data_p0 [4];
  logic [3:0]        h_valid_p0;
  logic [DATA_W-1:0] in_data [4];
  logic [3:0]        in_valid;
  logic [1:0]        w00;
  logic [1:0]        w11;

  assign in_data[0] = data_0;
  assign in_data[1] = data_1;
  assign in_data[2] = data_2;
  assign in_data[3] = data_3;
  assign in_valid   = {valid_3, valid_2, valid_1, valid_0};

  // phase=1 is a SLOT_A edge (words 0/2); phase=0 is a LOAD edge that emits words 1/3
  assign w00 = {1'b0, ~phase};
  assign w11 = {1'b1, ~phase};

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      phase      <= 1'b0;
      h_valid_p0 <= '0;
      for (int i = 0; i < 4; i++) h_data_p0[i] <= '0;
      data_00    <= '0;
      data_11    <= '0;
      valid_00   <= 1'b0;
      valid_11   <= 1'b0;
      slot_b     <= 1'b0;
      group_cnt  <= '0;
    end else begin
      phase    <= ~phase;
      slot_b   <= ~phase;
      valid_00 <= h_valid_p0[w00];
      valid_11 <= h_valid_p0[w11];
      // Invalid words leave the lane data untouched
      if (h_valid_p0[w00]) data_00 <= h_data_p0[w00];
      if (h_valid_p0[w11]) data_11 <= h_data_p0[w11];
      if (!phase) begin
        for (int i = 0; i < 4; i++) h_data_p0[i] <= in_data[i];
        h_valid_p0 <= in_valid;
        if (|in_valid) group_cnt <= group_cnt + 8'd1;
      end
    end
  end

endmodule
